// File: rtl/mcac_seq_pkg.sv
// Shared types and helpers for the MCAC per-sample stage sequencer.
// Holds the FSM state encoding, parameter defaults and the stage priority search.
package mcac_seq_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } seq_state_t;

   localparam int NUM_STAGES_DEF   = 8;
   localparam int STAGE_CYCLES_DEF = 4;
   localparam int IDX_W_DEF        = 4;
   localparam int MAX_STAGES       = 16;

   typedef struct packed {
      logic       found;
      logic [3:0] idx;
   } next_stage_t;

   // Lowest set bit of act at or above start. The start value may be one past the
   // top stage, which simply yields found=0.
   function automatic next_stage_t next_active(input logic [MAX_STAGES-1:0] act,
                                               input logic [4:0]            start);
      next_stage_t r;
      r.found = 1'b0;
      r.idx   = 4'd0;
      for (int i = MAX_STAGES - 1; i >= 0; i--) begin
         if (act[i] && (5'(i) >= start)) begin
            r.found = 1'b1;
            r.idx   = 4'(i);
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/mcac_stage_timer.sv
// Window counter for one stage: counts 0..STAGE_CYCLES-1 while enabled and
// flags the terminal count, which marks the last cycle of a stage window.
module mcac_stage_timer #(
   parameter int STAGE_CYCLES = 4
) (
   input  logic clk_i,
   input  logic reset_i,
   input  logic clear_i,
   input  logic en_i,
   output logic tc_o
);

   localparam int CNT_W = (STAGE_CYCLES > 1) ? $clog2(STAGE_CYCLES) : 1;

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   assign tc_o = (count_q == CNT_W'(STAGE_CYCLES - 1));

   // Wrapping at terminal count lets consecutive windows run with no gap.
   always_comb begin
      count_d = count_q;
      if (clear_i) begin
         count_d = '0;
      end else if (en_i) begin
         count_d = tc_o ? '0 : count_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/mcac_stage_seq.sv
// Per-sample stage sequencer: accepts a sample, then enables each non-skipped
// datapath stage in ascending order for a fixed window, then pulses sample_done.
module mcac_stage_seq
   import mcac_seq_pkg::*;
#(
   parameter int NUM_STAGES   = NUM_STAGES_DEF,
   parameter int STAGE_CYCLES = STAGE_CYCLES_DEF,
   parameter int IDX_W        = IDX_W_DEF
) (
   input  logic                  clk_i,
   input  logic                  reset_i,
   input  logic                  scan_in0_i,
   input  logic                  scan_en_i,
   output logic                  scan_out0_o,
   input  logic                  sample_valid_i,
   output logic                  sample_ready_o,
   input  logic [NUM_STAGES-1:0] skip_mask_i,
   input  logic                  overrun_clr_i,
   output logic [NUM_STAGES-1:0] stage_en_o,
   output logic                  stage_latch_o,
   output logic [IDX_W-1:0]      stage_idx_o,
   output logic                  sample_done_o,
   output logic                  busy_o,
   output logic                  overrun_o
);

   seq_state_t            state_q;
   logic [NUM_STAGES-1:0] skip_q;
   logic [IDX_W-1:0]      idx_q;
   logic [NUM_STAGES-1:0] stage_en_q;
   logic                  ready_q;
   logic                  done_q;
   logic                  busy_q;
   logic                  overrun_q;

   logic                  tc;
   logic [MAX_STAGES-1:0] act_in;
   logic [MAX_STAGES-1:0] act_q;
   next_stage_t           first_nxt;
   next_stage_t           adv_nxt;
   logic                  unused_scan;

   // Scan pins are stitched at DFT; they only need to be consumed here.
   assign unused_scan = ^{scan_in0_i, scan_en_i};
   assign scan_out0_o = 1'b0;

   mcac_stage_timer #(
      .STAGE_CYCLES(STAGE_CYCLES)
   ) u_timer (
      .clk_i  (clk_i),
      .reset_i(reset_i),
      .clear_i(state_q != RUN),
      .en_i   (state_q == RUN),
      .tc_o   (tc)
   );

   // Active-stage masks padded to the search width; the live mask is only used
   // at acceptance, the registered one for every later advance.
   always_comb begin
      act_in                   = '0;
      act_q                    = '0;
      act_in[NUM_STAGES-1:0]   = ~skip_mask_i;
      act_q[NUM_STAGES-1:0]    = ~skip_q;
      first_nxt                = next_active(act_in, 5'd0);
      adv_nxt                  = next_active(act_q, 5'(idx_q) + 5'd1);
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q    <= IDLE;
         skip_q     <= '0;
         idx_q      <= '0;
         stage_en_q <= '0;
         ready_q    <= 1'b1;
         done_q     <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (sample_valid_i) begin
                  skip_q  <= skip_mask_i;
                  ready_q <= 1'b0;
                  busy_q  <= 1'b1;
                  if (first_nxt.found) begin
                     state_q    <= RUN;
                     idx_q      <= IDX_W'(first_nxt.idx);
                     stage_en_q <= NUM_STAGES'(1) << first_nxt.idx;
                  end else begin
                     state_q <= DONE;
                     done_q  <= 1'b1;
                  end
               end
            end
            RUN: begin
               if (tc) begin
                  if (adv_nxt.found) begin
                     idx_q      <= IDX_W'(adv_nxt.idx);
                     stage_en_q <= NUM_STAGES'(1) << adv_nxt.idx;
                  end else begin
                     state_q    <= DONE;
                     idx_q      <= '0;
                     stage_en_q <= '0;
                     done_q     <= 1'b1;
                  end
               end
            end
            DONE: begin
               state_q <= IDLE;
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               ready_q <= 1'b1;
            end
            default: begin
               state_q    <= IDLE;
               idx_q      <= '0;
               stage_en_q <= '0;
               done_q     <= 1'b0;
               busy_q     <= 1'b0;
               ready_q    <= 1'b1;
            end
         endcase
      end
   end

   // A new overrun in the same cycle as a clear keeps the flag set.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         overrun_q <= 1'b0;
      end else if (sample_valid_i && busy_q) begin
         overrun_q <= 1'b1;
      end else if (overrun_clr_i) begin
         overrun_q <= 1'b0;
      end
   end

   assign sample_ready_o = ready_q;
   assign stage_en_o     = stage_en_q;
   assign stage_idx_o    = idx_q;
   assign stage_latch_o  = tc && (state_q == RUN);
   assign sample_done_o  = done_q;
   assign busy_o         = busy_q;
   assign overrun_o      = overrun_q;

endmodule
